// File: rtl/xadc_drp_arbiter.sv
// Round-robin arbiter sharing one XADC DRP port between NUM_REQ requesters.
// One transaction in flight at a time; a one-cycle ack returns read data or a timeout flag.
module xadc_drp_arbiter #(
    parameter int NUM_REQ        = 3,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TMO_W          = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_REQ-1:0]    req,
    input  logic [NUM_REQ-1:0]    req_we,
    input  logic [7*NUM_REQ-1:0]  req_addr,
    input  logic [16*NUM_REQ-1:0] req_di,
    output logic [NUM_REQ-1:0]    ack,
    output logic [15:0]           rd_data,
    output logic                  err,
    output logic                  busy,
    output logic [6:0]            drp_daddr,
    output logic                  drp_den,
    output logic                  drp_dwe,
    output logic [15:0]           drp_di,
    input  logic [15:0]           drp_do,
    input  logic                  drp_drdy
);

    localparam int IDX_W = $clog2(NUM_REQ);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_t;

    state_t           state;
    state_t           state_next;
    logic [IDX_W-1:0] rr_ptr;
    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] pick;
    logic             pick_valid;
    logic [TMO_W-1:0] tmo_cnt;
    logic             tmo_hit;
    logic [6:0]       addr_q;
    logic [15:0]      di_q;
    logic             we_q;
    logic             err_q;

    logic [6:0]  addr_arr [NUM_REQ];
    logic [15:0] di_arr   [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign addr_arr[g] = req_addr[7*g +: 7];
        assign di_arr[g]   = req_di[16*g +: 16];
    end

    assign tmo_hit = (tmo_cnt == TMO_W'(TIMEOUT_CYCLES));

    // Scan from the farthest offset down so the first set bit at or after rr_ptr wins.
    always_comb begin
        int               idx;
        logic [IDX_W-1:0] idx_l;
        pick       = rr_ptr;
        pick_valid = 1'b0;
        idx        = 0;
        idx_l      = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            idx = int'(rr_ptr) + i;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end
            idx_l = IDX_W'(idx);
            if (req[idx_l]) begin
                pick       = idx_l;
                pick_valid = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:  if (pick_valid) state_next = S_ISSUE;
            S_ISSUE: state_next = S_WAIT;
            S_WAIT:  if (drp_drdy || tmo_hit) state_next = S_DONE;
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_comb begin
        drp_den = (state == S_ISSUE);
        drp_dwe = (state == S_ISSUE) && we_q;
        busy    = (state != S_IDLE);
        ack     = (state == S_DONE) ? (NUM_REQ'(1) << winner) : '0;
        err     = (state == S_DONE) && err_q;
    end

    assign drp_daddr = addr_q;
    assign drp_di    = di_q;

    // drdy is only looked at in WAIT, so a late or stray drdy elsewhere is harmless.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            winner  <= '0;
            rr_ptr  <= '0;
            addr_q  <= '0;
            di_q    <= '0;
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            tmo_cnt <= '0;
            rd_data <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_valid) begin
                        winner <= pick;
                        addr_q <= addr_arr[pick];
                        di_q   <= di_arr[pick];
                        we_q   <= req_we[pick];
                    end
                end
                S_ISSUE: begin
                    tmo_cnt <= '0;
                    err_q   <= 1'b0;
                end
                S_WAIT: begin
                    if (drp_drdy) begin
                        err_q <= 1'b0;
                        if (!we_q) begin
                            rd_data <= drp_do;
                        end
                    end else if (tmo_hit) begin
                        err_q <= 1'b1;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    rr_ptr <= (winner == IDX_W'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
